// File: rtl/gr_file.sv
`default_nettype none
// ============================================================================
// Module      : gr_file
// Description : Parametrised general-register file. NREG registers of WIDTH
//               bits, two combinational read ports, one synchronous write
//               port, and a dump engine that streams every register out over
//               a valid/ready channel.
//               Optional feature macro: GR_FILE_BYPASS_EN
//                 defined     -> same-cycle write-through on rd0/rd1
//                 not defined -> reads return the stored (pre-write) value
// Revision    : 1.0 - initial release
// ============================================================================
module gr_file #(
    parameter int WIDTH   = 16,
    parameter int NREG    = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(NREG)-1:0]    wa,
    input  logic [WIDTH-1:0]           wd,
    input  logic [$clog2(NREG)-1:0]    ra0,
    output logic [WIDTH-1:0]           rd0,
    input  logic [$clog2(NREG)-1:0]    ra1,
    output logic [WIDTH-1:0]           rd1,
    input  logic                       dump_req,
    output logic                       dump_busy,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [$clog2(NREG)-1:0]    dump_idx,
    output logic [WIDTH-1:0]           dump_data,
    output logic                       dump_done
);

    localparam int            AW       = $clog2(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    // Dump engine states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [AW-1:0]    r_dump_idx;
    logic [AW-1:0]    w_dump_idx_nxt;

    logic             w_we_eff;
    logic [WIDTH-1:0] w_rd0_stored;
    logic [WIDTH-1:0] w_rd1_stored;
    logic [WIDTH-1:0] w_dump_data;

    // ------------------------------------------------------------------
    // Register 0 handling: either a hard-wired zero or a normal register.
    // Masking the read as well as the write keeps r0 at zero even if the
    // storage element were ever disturbed.
    // ------------------------------------------------------------------
    generate
        if (ZERO_R0 != 0) begin : g_zero_r0
            assign w_we_eff     = we && (wa != '0);
            assign w_rd0_stored = (ra0 == '0)        ? '0 : r_regs[ra0];
            assign w_rd1_stored = (ra1 == '0)        ? '0 : r_regs[ra1];
            assign w_dump_data  = (r_dump_idx == '0) ? '0 : r_regs[r_dump_idx];
        end else begin : g_plain_r0
            assign w_we_eff     = we;
            assign w_rd0_stored = r_regs[ra0];
            assign w_rd1_stored = r_regs[ra1];
            assign w_dump_data  = r_regs[r_dump_idx];
        end
    endgenerate

    // Register storage: async clear, single write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_eff) begin
            for (int i = 0; i < NREG; i++) begin
                if (wa == AW'(i)) begin
                    r_regs[i] <= wd;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Forwarding is suppressed while reset is asserted so the
    // file reads as all-zero during reset regardless of write traffic.
    // The dump channel always shows the stored value.
    // ------------------------------------------------------------------
`ifdef GR_FILE_BYPASS_EN
    logic w_byp0;
    logic w_byp1;

    assign w_byp0 = rst && w_we_eff && (wa == ra0);
    assign w_byp1 = rst && w_we_eff && (wa == ra1);
    assign rd0    = w_byp0 ? wd : w_rd0_stored;
    assign rd1    = w_byp1 ? wd : w_rd1_stored;
`else
    assign rd0    = w_rd0_stored;
    assign rd1    = w_rd1_stored;
`endif

    assign dump_idx  = r_dump_idx;
    assign dump_data = w_dump_data;

    // Dump FSM state and index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_dump_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dump_idx <= w_dump_idx_nxt;
        end
    end

    // Dump FSM next-state: requests only honoured in IDLE, index stops at
    // the last register and never wraps inside SCAN
    always_comb begin
        w_state_nxt    = r_state;
        w_dump_idx_nxt = r_dump_idx;
        case (r_state)
            S_IDLE: begin
                if (dump_req) begin
                    w_state_nxt    = S_SCAN;
                    w_dump_idx_nxt = '0;
                end
            end
            S_SCAN: begin
                if (dump_ready) begin
                    if (r_dump_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_dump_idx_nxt = r_dump_idx + AW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt    = S_IDLE;
                w_dump_idx_nxt = '0;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_dump_idx_nxt = '0;
            end
        endcase
    end

    // Dump FSM outputs, decoded from the current state only
    always_comb begin
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        case (r_state)
            S_SCAN: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
            end
            S_DONE: begin
                dump_busy  = 1'b1;
                dump_done  = 1'b1;
            end
            default: begin
                dump_busy  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/gr_file.md
# gr_file

Parametrised general-register file for the CPU data path, the successor to the fixed four-entry R0–R3 bank. It provides NREG registers of WIDTH bits with two combinational read ports and one synchronous write port. A built-in dump engine streams every register out over a valid/ready channel, so benches and debug logic can capture register state without hierarchical probing. It sits between the instruction decoder (addresses, write enable) and the ALU/bus (read data).

## Interface
Parameters:
- WIDTH, 16, register width in bits (≥1)
- NREG, 4, number of registers (power of two, ≥2); address width AW = $clog2(NREG)
- ZERO_R0, 0, when 1 register 0 reads as 0 and ignores writes

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- we  input  1  write enable
- wa  input  AW  write address
- wd  input  WIDTH  write data
- ra0  input  AW  read address, port 0
- rd0  output  WIDTH  read data, port 0
- ra1  input  AW  read address, port 1
- rd1  output  WIDTH  read data, port 1
- dump_req  input  1  start dump (sampled in IDLE only)
- dump_busy  output  1  dump engine active
- dump_valid  output  1  dump_idx/dump_data valid
- dump_ready  input  1  consumer accepts current entry
- dump_idx  output  AW  index of entry being offered
- dump_data  output  WIDTH  contents of register dump_idx
- dump_done  output  1  one-cycle pulse after last entry accepted

## Operation
- Reset (rst=0, asynchronous): all registers 0; FSM → IDLE; dump_busy=0, dump_valid=0, dump_idx=0, dump_done=0. Reset mid-dump aborts immediately; no dump_done.
- Write: on posedge with we=1, reg[wa] ← wd. With ZERO_R0=1 and wa=0, write is dropped.
- Read: rd0 = reg[ra0], rd1 = reg[ra1], combinational (see Configuration for same-cycle write). With ZERO_R0=1, address 0 returns 0.
- Dump FSM states:
  - IDLE: dump_valid=0, dump_busy=0. dump_req=1 → SCAN, dump_idx ← 0.
  - SCAN: dump_busy=1, dump_valid=1, dump_data = reg[dump_idx] (current stored value, ZERO_R0 rule applies). On dump_valid&dump_ready: if dump_idx=NREG-1 → DONE, else dump_idx+1. Without ready, idx/data hold (data may change only if that register is written).
  - DONE: dump_done=1, dump_busy=1, dump_valid=0 for exactly one cycle → IDLE, dump_idx ← 0.
- dump_req while SCAN/DONE is ignored (not queued). dump_req held high in IDLE restarts a dump after DONE.
- Writes remain fully operational during a dump. An entry is emitted with its value at the accepting edge; a write to that register on the same edge is not reflected (old value emitted).
- dump_idx never wraps inside SCAN; NREG-1 is terminal.

## Timing
- Write latency 1 cycle (visible on rd* after the edge).
- Read latency 0 (combinational from address).
- Dump: IDLE→first valid 1 cycle after dump_req edge; with dump_ready held 1, NREG consecutive beats, then dump_done one cycle later; total NREG+2 cycles from req to IDLE.
- Each stall cycle (dump_ready=0) adds one cycle; no entries are dropped or duplicated.

## Configuration
- GR_FILE_BYPASS_EN defined: when we=1 and wa=raN (and not the ZERO_R0 register), rdN = wd in the same cycle (write-through forwarding). dump_data is never bypassed.
- Not defined: rdN returns the stored (pre-write) value during the write cycle; new value appears after the edge.

## Test plan
- Reset: hold rst=0, drive we=1 wa=1 wd=16'hBEEF with clock → rd0(ra0=1)=0000, all dump outputs 0; release, next edge → rd0=BEEF.
- Write/read all: write reg[i]=16'h1111*(i+1), i=0..3 → rd0/rd1 return 1111,2222,3333,4444; ZERO_R0=1 build returns 0 for index 0.
- Bypass: we=1 wa=2 wd=ABCD, ra1=2 same cycle → rd1=ABCD with GR_FILE_BYPASS_EN, old value 3333 without.
- Dump, ready=1: pulse dump_req → dump_idx 0,1,2,3 on consecutive cycles with data 1111..4444, then dump_done=1 for one cycle, busy drops after it.
- Dump with backpressure and write: ready=0 for 3 cycles on idx 1 → idx/data stable; write reg[3]=5555 while idx=1 → idx 3 emits 5555; dump_req during SCAN has no effect.
- Reset mid-dump: assert rst=0 while dump_idx=2 → busy/valid drop immediately, no dump_done, registers 0.
